// File: rtl/ex_muldiv_unit_if.sv
// Execute-stage handshake between the dec/ex pipeline register and the mul/div unit.
// The bench or pipeline drives the instruction side, and the unit drives stall, busy and write-back.
interface ex_muldiv_unit_if #(
  parameter int DATA_WIDTH        = 32,
  parameter int REG_ADDR_WIDTH    = 5,
  parameter int ALU_CTLCODE_WIDTH = 8
);
  logic                         i_Valid;
  logic                         i_Flush;
  logic [ALU_CTLCODE_WIDTH-1:0] i_ALUCTL;
  logic [DATA_WIDTH-1:0]        i_Operand1;
  logic [DATA_WIDTH-1:0]        i_Operand2;
  logic [REG_ADDR_WIDTH-1:0]    i_Write_Addr;
  logic                         o_Stall;
  logic                         o_Busy;
  logic [DATA_WIDTH-1:0]        o_Result;
  logic                         o_Result_Valid;
  logic [REG_ADDR_WIDTH-1:0]    o_Write_Addr;

  modport master (
    output i_Valid, i_Flush, i_ALUCTL, i_Operand1, i_Operand2, i_Write_Addr,
    input  o_Stall, o_Busy, o_Result, o_Result_Valid, o_Write_Addr
  );

  modport slave (
    input  i_Valid, i_Flush, i_ALUCTL, i_Operand1, i_Operand2, i_Write_Addr,
    output o_Stall, o_Busy, o_Result, o_Result_Valid, o_Write_Addr
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/DIV (signed/unsigned) into HI/LO plus MFHI/MFLO/MTHI/MTLO; 34-cycle occupancy per long op.
// Stalls upstream combinationally while busy; MFxx results and MTxx writes take effect in the accept cycle.
module ex_muldiv_unit #(
  parameter int DATA_WIDTH        = 32,
  parameter int REG_ADDR_WIDTH    = 5,
  parameter int ALU_CTLCODE_WIDTH = 8
) (
  input  logic               i_Clk,
  input  logic               i_Reset_n,
  ex_muldiv_unit_if.slave    bus
);
  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH);

  localparam logic [ALU_CTLCODE_WIDTH-1:0] OP_MFHI  = 'h10;
  localparam logic [ALU_CTLCODE_WIDTH-1:0] OP_MTHI  = 'h11;
  localparam logic [ALU_CTLCODE_WIDTH-1:0] OP_MFLO  = 'h12;
  localparam logic [ALU_CTLCODE_WIDTH-1:0] OP_MTLO  = 'h13;
  localparam logic [ALU_CTLCODE_WIDTH-1:0] OP_MULT  = 'h18;
  localparam logic [ALU_CTLCODE_WIDTH-1:0] OP_MULTU = 'h19;
  localparam logic [ALU_CTLCODE_WIDTH-1:0] OP_DIV   = 'h1A;
  localparam logic [ALU_CTLCODE_WIDTH-1:0] OP_DIVU  = 'h1B;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [W-1:0]       hi, lo;
  logic [2*W-1:0]     acc;      // mul: {product hi, multiplier/product lo}; div: {remainder, quotient}
  logic [W-1:0]       opnd;     // multiplicand or divisor magnitude
  logic               is_div, neg_q, neg_r, div_zero;

  logic               md_op, long_op, busy, accept, is_signed, is_div_op;
  logic               neg1, neg2;
  logic [W-1:0]       mag1, mag2;
  logic [W:0]         mul_sum, div_shift;
  logic               div_take;
  logic [2*W-1:0]     acc_step, prod_fix;
  logic [W-1:0]       quo_fix, rem_fix;

  always_comb begin
    long_op = 1'b0;
    md_op   = 1'b0;
    if (bus.i_Valid && !bus.i_Flush) begin
      long_op = (bus.i_ALUCTL == OP_MULT) || (bus.i_ALUCTL == OP_MULTU) ||
                (bus.i_ALUCTL == OP_DIV)  || (bus.i_ALUCTL == OP_DIVU);
      md_op   = long_op ||
                (bus.i_ALUCTL == OP_MFHI) || (bus.i_ALUCTL == OP_MTHI) ||
                (bus.i_ALUCTL == OP_MFLO) || (bus.i_ALUCTL == OP_MTLO);
    end
  end

  assign busy      = (state != IDLE);
  assign accept    = md_op && !busy;
  assign is_signed = (bus.i_ALUCTL == OP_MULT) || (bus.i_ALUCTL == OP_DIV);
  assign is_div_op = (bus.i_ALUCTL == OP_DIV)  || (bus.i_ALUCTL == OP_DIVU);
  assign neg1      = is_signed && bus.i_Operand1[W-1];
  assign neg2      = is_signed && bus.i_Operand2[W-1];
  assign mag1      = neg1 ? -bus.i_Operand1 : bus.i_Operand1;
  assign mag2      = neg2 ? -bus.i_Operand2 : bus.i_Operand2;

  // One bit per cycle: shift-add multiply, or restoring divide.
  assign mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : '0);
  assign div_shift = {acc[2*W-1:W], acc[W-1]};
  assign div_take  = (div_shift >= {1'b0, opnd});

  always_comb begin
    if (is_div) begin
      if (div_take) begin
        acc_step = {div_shift[W-1:0] - opnd, acc[W-2:0], 1'b1};
      end else begin
        acc_step = {div_shift[W-1:0], acc[W-2:0], 1'b0};
      end
    end else begin
      acc_step = {mul_sum, acc[W-1:1]};
    end
  end

  assign prod_fix = neg_q ? -acc : acc;
  assign quo_fix  = neg_q ? -acc[W-1:0] : acc[W-1:0];
  assign rem_fix  = neg_r ? -acc[2*W-1:W] : acc[2*W-1:W];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && long_op) state_nxt = RUN;
      RUN:     if (cnt == CNT_W'(W - 1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      acc      <= '0;
      opnd     <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && long_op) begin
            cnt      <= '0;
            is_div   <= is_div_op;
            neg_q    <= neg1 ^ neg2;
            neg_r    <= neg1;
            div_zero <= is_div_op && (bus.i_Operand2 == '0);
            acc      <= {{W{1'b0}}, is_div_op ? mag1 : mag2};
            opnd     <= is_div_op ? mag2 : mag1;
          end
          if (accept && bus.i_ALUCTL == OP_MTHI) hi <= bus.i_Operand1;
          if (accept && bus.i_ALUCTL == OP_MTLO) lo <= bus.i_Operand1;
        end
        RUN: begin
          acc <= acc_step;
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          // Divide by zero leaves the quotient all ones; the remainder fixup restores the dividend.
          if (is_div) begin
            lo <= div_zero ? '1 : quo_fix;
            hi <= rem_fix;
          end else begin
            lo <= prod_fix[W-1:0];
            hi <= prod_fix[2*W-1:W];
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.o_Result_Valid = 1'b0;
    bus.o_Result       = '0;
    if (accept && (bus.i_ALUCTL == OP_MFHI || bus.i_ALUCTL == OP_MFLO)) begin
      bus.o_Result_Valid = 1'b1;
      bus.o_Result       = (bus.i_ALUCTL == OP_MFHI) ? hi : lo;
    end
  end

  assign bus.o_Stall      = md_op && busy;
  assign bus.o_Busy       = busy;
  assign bus.o_Write_Addr = bus.i_Write_Addr;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: MFxx results go through an expected-value queue checked by a monitor.
module tb_ex_muldiv_unit;
  localparam logic [7:0] MFHI = 8'h10, MTHI = 8'h11, MFLO = 8'h12, MTLO = 8'h13;
  localparam logic [7:0] MULT = 8'h18, MULTU = 8'h19, DIV = 8'h1A, DIVU = 8'h1B;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] exp_res[$];
  logic [4:0]  exp_addr[$];

  ex_muldiv_unit_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .ALU_CTLCODE_WIDTH(8)) bus ();

  ex_muldiv_unit #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .ALU_CTLCODE_WIDTH(8)) dut (
    .i_Clk     (clk),
    .i_Reset_n (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write-back the DUT presents must match the oldest expectation.
  always @(negedge clk) begin
    if (bus.o_Result_Valid === 1'b1) begin
      if (exp_res.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %0h at addr %0d, expected none", bus.o_Result, bus.o_Write_Addr);
      end else begin
        chk("result", {27'd0, bus.o_Write_Addr, bus.o_Result}, {27'd0, exp_addr.pop_front(), exp_res.pop_front()});
      end
    end
  end

  task automatic idle_inputs();
    bus.i_Valid = 1'b0; bus.i_Flush = 1'b0; bus.i_ALUCTL = '0;
    bus.i_Operand1 = '0; bus.i_Operand2 = '0; bus.i_Write_Addr = '0;
  endtask

  // Present one instruction from just after a rising edge; hold it until accepted.
  task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] wa, output int stalls);
    bus.i_Valid = 1'b1; bus.i_Flush = 1'b0; bus.i_ALUCTL = op;
    bus.i_Operand1 = a; bus.i_Operand2 = b; bus.i_Write_Addr = wa;
    stalls = 0;
    @(negedge clk);
    while (bus.o_Stall === 1'b1 && stalls < 200) begin
      stalls++;
      @(negedge clk);
    end
    if (stalls >= 200) begin
      checks++; errors++;
      $display("FAIL stall_timeout: stalled %0d cycles, limit 200", stalls);
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic read(input logic [7:0] op, input logic [4:0] wa, input logic [31:0] exp);
    int s;
    exp_res.push_back(exp);
    exp_addr.push_back(wa);
    issue(op, 32'd0, 32'd0, wa, s);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    @(negedge clk);
    while (bus.o_Busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    @(posedge clk); #1;
  endtask

  typedef struct { logic [7:0] op; logic [31:0] a, b, lo, hi; } vec_t;
  vec_t vecs[6] = '{
    '{DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF},
    '{DIVU,  32'd100,      32'd0,        32'hFFFFFFFF, 32'd100},
    '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000},
    '{DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFF9},
    '{DIVU,  32'd1000,     32'd7,        32'd142,      32'd6},
    '{MULT,  32'hFFFFFFF9, 32'hFFFFFFFD, 32'd21,       32'd0}
  };

  initial begin
    int s, n;
    idle_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", bus.o_Busy, 0);
    chk("rst_stall", bus.o_Stall, 0);
    chk("rst_res_vld", bus.o_Result_Valid, 0);
    chk("rst_result", bus.o_Result, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    read(MFHI, 5'd3, 32'd0);
    read(MFLO, 5'd4, 32'd0);

    // Signed multiply with an MFLO queued behind it from cycle 1.
    issue(MULT, 32'hFFFFFFFE, 32'd3, 5'd0, s);
    exp_res.push_back(32'hFFFFFFFA); exp_addr.push_back(5'd7);
    issue(MFLO, 32'd0, 32'd0, 5'd7, s);
    chk("mult_stall_cycles", s, 33);
    read(MFHI, 5'd8, 32'hFFFFFFFF);

    issue(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, s);
    wait_idle(n);
    chk("multu_busy_cycles", n, 33);
    read(MFHI, 5'd9, 32'hFFFFFFFE);
    read(MFLO, 5'd10, 32'h00000001);

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, 5'd0, s);
      wait_idle(n);
      read(MFLO, 5'(11 + i), vecs[i].lo);
      read(MFHI, 5'(17 + i), vecs[i].hi);
    end

    issue(MTHI, 32'h1234, 32'd0, 5'd0, s);
    exp_res.push_back(32'h1234); exp_addr.push_back(5'd23);
    issue(MFHI, 32'd0, 32'd0, 5'd23, s);
    chk("mfhi_after_mthi_stalls", s, 0);

    // Flushed MTLO held across a whole long op and the following idle edges.
    issue(MULTU, 32'd7, 32'd8, 5'd0, s);
    bus.i_Valid = 1'b1; bus.i_Flush = 1'b1; bus.i_ALUCTL = MTLO; bus.i_Operand1 = 32'hDEAD;
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.o_Stall !== 1'b0) n++;
    end
    chk("flush_stall_cycles", n, 0);
    @(posedge clk); #1;
    idle_inputs();
    read(MFLO, 5'd24, 32'd56);

    // Back-to-back long ops: the second waits out the first.
    issue(MULTU, 32'd2, 32'd3, 5'd0, s);
    issue(DIVU, 32'd9, 32'd2, 5'd0, s);
    chk("b2b_stall_cycles", s, 33);
    exp_res.push_back(32'd4); exp_addr.push_back(5'd25);
    issue(MFLO, 32'd0, 32'd0, 5'd25, s);
    chk("b2b_mflo_stall", s, 33);
    read(MFHI, 5'd26, 32'd1);

    // Reset in the middle of a divide.
    issue(DIVU, 32'd1000, 32'd7, 5'd0, s);
    repeat (9) @(posedge clk);
    #1;
    chk("pre_reset_busy", bus.o_Busy, 1);
    rst_n = 1'b0;
    #1;
    chk("reset_busy", bus.o_Busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    read(MFHI, 5'd27, 32'd0);
    read(MFLO, 5'd28, 32'd0);
    issue(MULTU, 32'd5, 32'd6, 5'd0, s);
    wait_idle(n);
    chk("post_reset_busy_cycles", n, 33);
    read(MFLO, 5'd29, 32'd30);
    read(MFHI, 5'd30, 32'd0);

    repeat (4) @(posedge clk);
    chk("scoreboard_empty", exp_res.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
